led_sequencer: RTL and testbench
================================

// Module: led_sequencer
// PURPOSE
//   Parametrised LED pattern engine for the front-panel LED bank. Replaces the fixed
//   bounce shifter with a sequencer that has runtime mode select, a built-in step-rate
//   prescaler, pause, and an end-of-sequence strobe. Sits between the system clock
//   domain and the board LED pins; the control FSM drives mode/en.
// PARAMETERS
//   LED_W   10  number of LEDs driven; LED_W >= 2 (elaborate-time error otherwise)
//   DIV_W   24  width of prescaler counter and step_div port
//   POS_W   $clog2(LED_W)  width of pos output (localparam, derived)
// PORTS
//   clk       in   1       system clock
//   reset     in   1       asynchronous, active-high reset
//   en        in   1       1 = sequence runs; 0 = freeze pattern and prescaler
//   mode      in   2       0 BOUNCE, 1 ROTATE, 2 FILL, 3 BLINK
//   step_div  in   DIV_W   clk cycles per step minus 1 (0 = step every clk)
//   led       out  LED_W   LED drive, bit 0 = leftmost-start LED
//   pos       out  POS_W   current sequence position
//   wrap      out  1       one-clk pulse when sequence returns to start state
// BEHAVIOUR
//   Reset: mode_q=0 (BOUNCE), pos=0, dir=up, presc=0, wrap=0 -> led = 0..01.
//   Prescaler: presc counts 0..step_div; tick when presc==step_div & en, then presc<=0.
//     step_div lowered below presc: tick on presc==step_div never hit -> presc wraps
//     at 2^DIV_W; implementation MUST instead tick and clear when presc >= step_div.
//   en=0: pos, dir, presc, wrap(=0) hold; led holds.
//   Mode change (mode != mode_q): mode_q<=mode, pos<=0, dir<=up, presc<=0, no tick,
//     wrap=0; new pattern visible next cycle. Mode change has priority over tick.
//   On tick, per mode_q:
//     BOUNCE: pos steps +1 while dir=up, -1 while down; reverses at LED_W-1 and 0
//       (end LEDs shown once, no dwell). Period 2*(LED_W-1). wrap when pos 1->0.
//     ROTATE: pos = (pos+1) mod LED_W. wrap when pos LED_W-1 -> 0.
//     FILL:   pos = (pos+1) mod LED_W; led = (2<<pos)-1 (pos+1 LEDs lit). wrap on 0.
//     BLINK:  pos toggles 0/1; pos0 led = all ones, pos1 led = all zeros. wrap on ->0.
//   led = combinational decode of registered {mode_q,pos} (plus trail, below);
//     BOUNCE/ROTATE: one-hot at pos.
//   wrap registered: asserted the cycle pos shows the start state, for one clk only.
//   Reset mid-sequence: immediate return to reset state, no wrap pulse.
// CONFIGURATION
//   LED_SEQ_TRAIL_EN defined: BOUNCE/ROTATE additionally light the previously visited
//     LED at 25% duty (on when free-running 2-bit pwm_cnt==0; pwm_cnt resets to 0);
//     prev_pos register resets to 0 and is cleared to pos on mode change, so no trail
//     is shown until the first tick. FILL/BLINK unaffected.
//   Undefined: BOUNCE/ROTATE strictly one-hot; no pwm_cnt/prev_pos logic.
// STRUCTURE
//   led_seq_defs.vh: mode encodings (LED_SEQ_BOUNCE/ROTATE/FILL/BLINK), shared with
//     the control FSM and the bench.
//   Sub-module tick_divider (DIV_W param): presc counter, en, clear, step_div -> tick.
//   Sequencer state (mode_q, pos, dir, wrap) and led decode live in led_sequencer.
// TESTING
//   1 reset asserted mid-run, LED_W=10 -> led=10'h001, pos=0, wrap=0 asynchronously.
//   2 BOUNCE, step_div=0, en=1, 20 clks -> pos 0,1..9,8..1,0,1; wrap once at clk 18.
//   3 ROTATE, step_div=3 -> pos advances every 4th clk; wrap after 40 clks; en=0 for
//     7 clks mid-step -> step resumes with presc count preserved.
//   4 FILL then mode->BLINK at pos=5 -> next clk pos=0, led=10'h3FF; after 1 tick 0.
//   5 step_div 100->2 while presc=50 -> tick next clk, then every 3 clks.
//   6 TRAIL_EN build, ROTATE pos=4 -> led[4]=1 always, led[3] high 1 of every 4 clks.

Source files
------------

// File: rtl/led_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// led_sequencer_pkg
//   Shared definitions for the front-panel LED sequencer: the pattern mode
//   encodings used by the sequencer, the control FSM that drives it, and the
//   bench.
// ---------------------------------------------------------------------------
package led_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BLINK  = 2'd3
    } led_mode_e;

endpackage

// File: rtl/led_sequencer_tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
//   Step-rate prescaler. Counts enabled clocks and emits one tick every
//   step_div_i+1 of them.
// Ports
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   en_i         count enable; when low the count and tick are frozen
//   clear_i      synchronous clear of the count, suppresses the tick
//   step_div_i   clk cycles per tick minus 1
//   tick_o       combinational tick, valid in the cycle the count reaches the limit
// ---------------------------------------------------------------------------
module tick_divider #(
    parameter int DIV_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic [DIV_W-1:0] step_div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] presc_q;
    logic             at_limit;

    // ">=" rather than "==": if step_div_i is lowered below the current count
    // the counter must not run all the way round to 2^DIV_W before ticking.
    assign at_limit = (presc_q >= step_div_i);
    assign tick_o   = en_i & ~clear_i & at_limit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
        end else if (clear_i) begin
            presc_q <= '0;
        end else if (en_i) begin
            presc_q <= at_limit ? '0 : presc_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
//   LED pattern engine for the front-panel LED bank: runtime mode select
//   (BOUNCE / ROTATE / FILL / BLINK), step-rate prescaler, pause and an
//   end-of-sequence strobe.
// Parameters
//   LED_W      number of LEDs (>= 2)
//   DIV_W      prescaler / step_div width
// Ports
//   clk        system clock
//   reset      asynchronous active-high reset
//   en         1 = run, 0 = freeze pattern and prescaler
//   mode       requested pattern (led_mode_e encoding)
//   step_div   clk cycles per step minus 1
//   led        LED drive, bit 0 = start LED
//   pos        current sequence position
//   wrap       one-clk pulse when the sequence returns to its start state
// Configuration
//   LED_SEQ_TRAIL_EN  when defined, BOUNCE/ROTATE also light the previously
//                     visited LED at 25% duty.
// ---------------------------------------------------------------------------
module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter  int LED_W = 10,
    parameter  int DIV_W = 24,
    localparam int POS_W = $clog2(LED_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] step_div,
    output logic [LED_W-1:0] led,
    output logic [POS_W-1:0] pos,
    output logic             wrap
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(LED_W - 1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [LED_W-1:0] LED_ONE = LED_W'(1);

    generate
        if (LED_W < 2) begin : g_bad_led_w
            $error("led_sequencer: LED_W must be at least 2");
        end
    endgenerate

    led_mode_e        mode_q;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_up_q, dir_up_d;
    logic             wrap_q;
    logic             mode_chg;
    logic             tick;
    logic [LED_W-1:0] onehot;
    logic [LED_W-1:0] trail_bits;

    assign mode_chg = (mode != mode_q);

    tick_divider #(
        .DIV_W (DIV_W)
    ) u_tick_divider (
        .clk_i      (clk),
        .rst_i      (reset),
        .en_i       (en),
        .clear_i    (mode_chg),
        .step_div_i (step_div),
        .tick_o     (tick)
    );

    // Position/direction after one step of the current pattern.
    always_comb begin
        pos_d    = pos_q;
        dir_up_d = dir_up_q;
        case (mode_q)
            MODE_BOUNCE: begin
                pos_d = dir_up_q ? pos_q + POS_ONE : pos_q - POS_ONE;
                // Direction flips on arrival at an end, so each end LED is
                // shown for exactly one step.
                if (pos_d == POS_MAX) begin
                    dir_up_d = 1'b0;
                end else if (pos_d == '0) begin
                    dir_up_d = 1'b1;
                end
            end
            MODE_ROTATE, MODE_FILL: begin
                pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_ONE;
            end
            MODE_BLINK: begin
                pos_d = (pos_q == '0) ? POS_ONE : '0;
            end
            default: begin
                pos_d = pos_q;
            end
        endcase
    end

    // Sequencer state. A mode change wins over a tick and restarts the
    // pattern without a wrap pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q   <= MODE_BOUNCE;
            pos_q    <= '0;
            dir_up_q <= 1'b1;
            wrap_q   <= 1'b0;
        end else if (mode_chg) begin
            mode_q   <= led_mode_e'(mode);
            pos_q    <= '0;
            dir_up_q <= 1'b1;
            wrap_q   <= 1'b0;
        end else if (tick) begin
            pos_q    <= pos_d;
            dir_up_q <= dir_up_d;
            wrap_q   <= (pos_d == '0);
        end else begin
            wrap_q   <= 1'b0;
        end
    end

`ifdef LED_SEQ_TRAIL_EN
    logic [1:0]       pwm_cnt_q;
    logic [POS_W-1:0] prev_pos_q;

    // prev_pos follows pos to 0 on a mode change, so the trail lands on the
    // lit LED itself until the first step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt_q  <= 2'd0;
            prev_pos_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 2'd1;
            if (mode_chg) begin
                prev_pos_q <= '0;
            end else if (tick) begin
                prev_pos_q <= pos_q;
            end
        end
    end

    assign trail_bits = (pwm_cnt_q == 2'd0) ? (LED_ONE << prev_pos_q) : '0;
`else
    assign trail_bits = '0;
`endif

    assign onehot = LED_ONE << pos_q;

    always_comb begin
        led = '0;
        case (mode_q)
            MODE_BOUNCE, MODE_ROTATE: led = onehot | trail_bits;
            // All LEDs below pos plus pos itself: pos+1 LEDs lit.
            MODE_FILL:                led = ~({LED_W{1'b1}} << pos_q) | onehot;
            MODE_BLINK:               led = (pos_q == '0) ? '1 : '0;
            default:                  led = '0;
        endcase
    end

    assign pos  = pos_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;
    import led_sequencer_pkg::*;

    localparam int LED_W = 10;
    localparam int DIV_W = 24;
    localparam int POS_W = $clog2(LED_W);
    localparam int SB_W  = LED_W + POS_W + 1;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] step_div;
    logic [LED_W-1:0] led;
    logic [POS_W-1:0] pos;
    logic             wrap;

    always #5 clk = ~clk;

    led_sequencer #(
        .LED_W (LED_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .step_div (step_div),
        .led      (led),
        .pos      (pos),
        .wrap     (wrap)
    );

    // ---------------- scoreboard + reference model ----------------
    int checks = 0;
    int errors = 0;
    logic [SB_W-1:0] exp_q[$];

    logic [1:0] m_mode;
    int         m_pos;
    bit         m_dir_up;
    int         m_presc;
    bit         m_wrap;
    int         m_prev;
    int         m_pwm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = MODE_BOUNCE;
        m_pos    = 0;
        m_dir_up = 1'b1;
        m_presc  = 0;
        m_wrap   = 1'b0;
        m_prev   = 0;
        m_pwm    = 0;
    endtask

    // Advances the model by one clock edge with the given inputs.
    task automatic model_clock(input logic e, input logic [1:0] m, input int sd);
        m_pwm = (m_pwm + 1) % 4;
        if (m != m_mode) begin
            m_mode   = m;
            m_pos    = 0;
            m_dir_up = 1'b1;
            m_presc  = 0;
            m_wrap   = 1'b0;
            m_prev   = 0;
        end else if (e && m_presc >= sd) begin
            m_presc = 0;
            m_prev  = m_pos;
            case (m_mode)
                MODE_BOUNCE: begin
                    if (m_dir_up) m_pos++;
                    else          m_pos--;
                    if (m_pos == LED_W - 1) m_dir_up = 1'b0;
                    if (m_pos == 0)         m_dir_up = 1'b1;
                end
                MODE_BLINK: m_pos = 1 - m_pos;
                default:    m_pos = (m_pos + 1) % LED_W;
            endcase
            m_wrap = (m_pos == 0);
        end else begin
            if (e) m_presc++;
            m_wrap = 1'b0;
        end
    endtask

    function automatic logic [LED_W-1:0] model_led();
        logic [LED_W-1:0] l;
        l = '0;
        case (m_mode)
            MODE_BOUNCE, MODE_ROTATE: begin
                l[m_pos] = 1'b1;
`ifdef LED_SEQ_TRAIL_EN
                if (m_pwm == 0) l[m_prev] = 1'b1;
`endif
            end
            MODE_FILL: begin
                for (int i = 0; i < LED_W; i++) if (i <= m_pos) l[i] = 1'b1;
            end
            default: begin
                if (m_pos == 0) l = '1;
            end
        endcase
        return l;
    endfunction

    task automatic sb_check();
        logic [SB_W-1:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got no expected entry at %0t", $time);
        end else begin
            exp = exp_q.pop_front();
            check("sb_led_pos_wrap", {led, pos, wrap}, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1; drives inputs, predicts, clocks once, compares.
    task automatic step(input logic e, input logic [1:0] m, input logic [DIV_W-1:0] sd);
        en       = e;
        mode     = m;
        step_div = sd;
        model_clock(e, m, int'(sd));
        exp_q.push_back({model_led(), POS_W'(m_pos), m_wrap});
        @(posedge clk);
        #1;
        sb_check();
    endtask

    typedef struct {
        logic             en;
        logic [1:0]       mode;
        logic [DIV_W-1:0] sd;
        int               exp_pos;
        logic             exp_wrap;
    } vec_t;

    vec_t bounce_tbl[20];

    initial begin
        int p;
        int nwrap;
        int clk_n;
        logic [1:0] rm;

        // bounce vectors: up 1..9, down 8..0 (wrap on arrival at 0), up again
        for (int k = 0; k < 20; k++) begin
            clk_n = k + 1;
            bounce_tbl[k].en       = 1'b1;
            bounce_tbl[k].mode     = MODE_BOUNCE;
            bounce_tbl[k].sd       = '0;
            bounce_tbl[k].exp_pos  = (clk_n <= 9) ? clk_n : ((clk_n <= 18) ? 18 - clk_n : clk_n - 18);
            bounce_tbl[k].exp_wrap = (clk_n == 18);
        end

        reset    = 1'b1;
        en       = 1'b0;
        mode     = MODE_BOUNCE;
        step_div = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_led", led, 32'h001);
        check("reset_pos", pos, 32'h0);
        check("reset_wrap", wrap, 32'h0);
        reset = 1'b0;

        // BOUNCE, step every clk
        for (int k = 0; k < 20; k++) begin
            step(bounce_tbl[k].en, bounce_tbl[k].mode, bounce_tbl[k].sd);
            check("bounce_pos", pos, bounce_tbl[k].exp_pos);
            check("bounce_wrap", wrap, bounce_tbl[k].exp_wrap);
        end

        // asynchronous reset mid-run
        repeat (3) step(1'b1, MODE_BOUNCE, '0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_led", led, 32'h001);
        check("async_reset_pos", pos, 32'h0);
        check("async_reset_wrap", wrap, 32'h0);
        @(posedge clk);
        #1;
        check("held_reset_wrap", wrap, 32'h0);
        reset = 1'b0;
        model_reset();
        step(1'b1, MODE_BOUNCE, '0);
        check("post_reset_pos", pos, 32'h1);

        // ROTATE, step_div=3: one step every 4 clks, wrap after 40
        step(1'b1, MODE_ROTATE, 24'd3);
        check("rotate_enter_pos", pos, 32'h0);
        nwrap = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, MODE_ROTATE, 24'd3);
            if (wrap) nwrap++;
            if (i == 4) check("rotate_first_step", pos, 32'h1);
        end
        check("rotate_wrap_count", nwrap, 1);
        check("rotate_wrap_at_40", wrap, 32'h1);
        // pause mid-step: presc count must survive
        repeat (2) step(1'b1, MODE_ROTATE, 24'd3);
        p = int'(pos);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, MODE_ROTATE, 24'd3);
            check("pause_pos", pos, p);
            check("pause_wrap", wrap, 32'h0);
        end
        step(1'b1, MODE_ROTATE, 24'd3);
        check("resume_hold", pos, p);
        step(1'b1, MODE_ROTATE, 24'd3);
        check("resume_step", pos, (p + 1) % LED_W);

        // FILL up to pos 5, then switch to BLINK
        step(1'b1, MODE_FILL, '0);
        check("fill_enter_led", led, 32'h001);
        repeat (5) step(1'b1, MODE_FILL, '0);
        check("fill_pos5_led", led, 32'h03F);
        step(1'b1, MODE_BLINK, '0);
        check("blink_enter_pos", pos, 32'h0);
        check("blink_enter_led", led, 32'h3FF);
        check("blink_enter_wrap", wrap, 32'h0);
        step(1'b1, MODE_BLINK, '0);
        check("blink_tick_led", led, 32'h000);
        step(1'b1, MODE_BLINK, '0);
        check("blink_back_wrap", wrap, 32'h1);

        // step_div lowered below the running count
        step(1'b1, MODE_ROTATE, 24'd100);
        repeat (50) step(1'b1, MODE_ROTATE, 24'd100);
        check("slow_no_step", pos, 32'h0);
        step(1'b1, MODE_ROTATE, 24'd2);
        check("lowered_div_tick", pos, 32'h1);
        repeat (2) step(1'b1, MODE_ROTATE, 24'd2);
        check("lowered_div_hold", pos, 32'h1);
        step(1'b1, MODE_ROTATE, 24'd2);
        check("lowered_div_next", pos, 32'h2);

`ifdef LED_SEQ_TRAIL_EN
        // trail: ROTATE held at pos 4, prev LED 3 at 25% duty
        step(1'b1, MODE_BOUNCE, '0);
        step(1'b1, MODE_ROTATE, '0);
        repeat (4) step(1'b1, MODE_ROTATE, '0);
        nwrap = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, MODE_ROTATE, '0);
            check("trail_cur_led", led[4], 32'h1);
            if (led[3]) nwrap++;
        end
        check("trail_duty", nwrap, 2);
`endif

        // random run against the model
        rm = MODE_BOUNCE;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) rm = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 3) != 0), rm, DIV_W'($urandom_range(0, 3)));
        end

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
